// File: rtl/lifo_param_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lifo_param_pkg
// Description : Shared definitions for the parametrised LIFO. It provides the
//               clog2 helpers that size the count and address buses, and the
//               operation encoding built from {wn, rn}.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package lifo_param_pkg;

  // Encoding of {wn, rn}. The bit order matches the request pins directly.
  localparam logic [1:0] OP_IDLE = 2'b00;
  localparam logic [1:0] OP_POP  = 2'b01;
  localparam logic [1:0] OP_PUSH = 2'b10;
  localparam logic [1:0] OP_REPL = 2'b11;

  // ceil(log2(value)). The result is 0 for value <= 1.
  function automatic int lifo_clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // Width of a counter that has to represent 0..depth inclusive.
  function automatic int lifo_cw(input int depth);
    return lifo_clog2(depth + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/lifo_param_mem.sv
`default_nettype none
// ============================================================================
// Module      : lifo_param_mem
// Description : WIDTH x DEPTH register array with one synchronous write port
//               and one asynchronous read port. The contents are not reset.
// Ports       : clk   - rising-edge clock
//               we    - write enable
//               waddr - write address
//               wdata - write data
//               raddr - read address (combinational read)
//               rdata - read data
// Revision    : 1.0 - initial release
// ============================================================================
module lifo_param_mem
  import lifo_param_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic [lifo_clog2(DEPTH)-1:0]   waddr,
  input  logic [WIDTH-1:0]               wdata,
  input  logic [lifo_clog2(DEPTH)-1:0]   raddr,
  output logic [WIDTH-1:0]               rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // The controller asserts we only with waddr < DEPTH. This keeps every write
  // in range when DEPTH is not a power of two.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/lifo_param.sv
`default_nettype none
// ============================================================================
// Module      : lifo_param
// Description : Parametrised synchronous LIFO stack. It provides an occupancy
//               count, an almost-full flag, replace-top and pass-through on a
//               simultaneous push/pop, a synchronous flush, and sticky
//               overflow/underflow flags.
// Ports       : clk, rst      - clock, async active-high reset
//               in, wn, rn    - push data, push request, pop request
//               flush         - synchronous clear of the stack
//               err_clr       - synchronous clear of the sticky error flags
//               out,out_valid - registered pop data, one-cycle update pulse
//               full, empty, almost_full, count - occupancy status
//               overflow, underflow - sticky error flags
// Revision    : 1.0 - initial release
// ============================================================================
module lifo_param
  import lifo_param_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = DEPTH - 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [WIDTH-1:0]            in,
  input  logic                        wn,
  input  logic                        rn,
  input  logic                        flush,
  input  logic                        err_clr,
  output logic [WIDTH-1:0]            out,
  output logic                        out_valid,
  output logic                        full,
  output logic                        empty,
  output logic                        almost_full,
  output logic [lifo_cw(DEPTH)-1:0]   count,
  output logic                        overflow,
  output logic                        underflow
);

  localparam int CW = lifo_cw(DEPTH);
  localparam int AW = lifo_clog2(DEPTH);

  localparam logic [CW-1:0] c_one   = CW'(1);
  localparam logic [CW-1:0] c_depth = CW'(DEPTH);
  localparam logic [CW-1:0] c_af    = CW'(AF_THRESH);

  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_out;
  logic             r_out_valid;
  logic             r_ovf;
  logic             r_unf;

  logic [1:0]       w_op;
  logic             w_full;
  logic             w_empty;
  logic [AW-1:0]    w_top_addr;
  logic [AW-1:0]    w_push_addr;
  logic [WIDTH-1:0] w_rdata;

  logic [CW-1:0]    w_count_nxt;
  logic [WIDTH-1:0] w_out_nxt;
  logic             w_valid_nxt;
  logic             w_ovf_set;
  logic             w_unf_set;
  logic             w_we;
  logic [AW-1:0]    w_waddr;

  assign w_op    = {wn, rn};
  assign w_full  = (r_count == c_depth);
  assign w_empty = (r_count == '0);

  // The top of the stack is mem[count-1]. When count is 0 this address wraps,
  // but nothing reads it while the stack is empty. The next free slot is
  // mem[count], and it is only written while the stack is not full.
  assign w_top_addr  = AW'(r_count - c_one);
  assign w_push_addr = AW'(r_count);

  lifo_param_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (w_we),
    .waddr (w_waddr),
    .wdata (in),
    .raddr (w_top_addr),
    .rdata (w_rdata)
  );

  always_comb begin
    w_count_nxt = r_count;
    w_out_nxt   = r_out;
    w_valid_nxt = 1'b0;
    w_ovf_set   = 1'b0;
    w_unf_set   = 1'b0;
    w_we        = 1'b0;
    w_waddr     = w_push_addr;
    if (flush) begin
      w_count_nxt = '0;
    end else begin
      case (w_op)
        OP_PUSH: begin
          if (w_full) begin
            w_ovf_set = 1'b1;
          end else begin
            w_we        = 1'b1;
            w_count_nxt = r_count + c_one;
          end
        end
        OP_POP: begin
          if (w_empty) begin
            w_unf_set = 1'b1;
          end else begin
            w_out_nxt   = w_rdata;
            w_valid_nxt = 1'b1;
            w_count_nxt = r_count - c_one;
          end
        end
        OP_REPL: begin
          w_valid_nxt = 1'b1;
          if (w_empty) begin
            // Nothing is stored, so the pushed word goes straight out.
            w_out_nxt = in;
          end else begin
            // The old top leaves through out. The new word takes its slot,
            // so count stays the same even when the stack is full.
            w_out_nxt = w_rdata;
            w_we      = 1'b1;
            w_waddr   = w_top_addr;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count     <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_count     <= w_count_nxt;
      r_out       <= w_out_nxt;
      r_out_valid <= w_valid_nxt;
    end
  end

  // A new error on the same edge as err_clr keeps its flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      if (w_ovf_set) begin
        r_ovf <= 1'b1;
      end else if (err_clr) begin
        r_ovf <= 1'b0;
      end
      if (w_unf_set) begin
        r_unf <= 1'b1;
      end else if (err_clr) begin
        r_unf <= 1'b0;
      end
    end
  end

  assign count       = r_count;
  assign out         = r_out;
  assign out_valid   = r_out_valid;
  assign full        = w_full;
  assign empty       = w_empty;
  assign almost_full = (r_count >= c_af);
  assign overflow    = r_ovf;
  assign underflow   = r_unf;

endmodule
`default_nettype wire

// File: tb/tb_lifo_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_lifo_param
// Description : Self-checking bench for lifo_param with default parameters.
//               A behavioural stack model predicts the state. Words expected
//               on out are queued when a pop is driven, and they are compared
//               when the DUT raises out_valid.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lifo_param;

  logic       clk;
  logic       rst;
  logic [7:0] din;
  logic       wn;
  logic       rn;
  logic       flush;
  logic       err_clr;
  logic [7:0] dout;
  logic       out_valid;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic [3:0] count;
  logic       overflow;
  logic       underflow;

  lifo_param #(
    .WIDTH     (8),
    .DEPTH     (8),
    .AF_THRESH (7)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in          (din),
    .wn          (wn),
    .rn          (rn),
    .flush       (flush),
    .err_clr     (err_clr),
    .out         (dout),
    .out_valid   (out_valid),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_err;
  int         n_chk;
  logic [7:0] mstk[$];
  logic [7:0] sb[$];
  logic [7:0] m_out;
  logic       m_ovf;
  logic       m_unf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    mstk.delete();
    sb.delete();
    m_out = 8'd0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic chk_status();
    chk("out",         dout,        m_out);
    chk("count",       count,       mstk.size());
    chk("empty",       empty,       mstk.size() == 0);
    chk("full",        full,        mstk.size() == 8);
    chk("almost_full", almost_full, mstk.size() >= 7);
    chk("overflow",    overflow,    m_ovf);
    chk("underflow",   underflow,   m_unf);
  endtask

  // Drive one cycle of requests, then check the result 1 ns after the edge.
  task automatic step(input logic w, input logic r, input logic [7:0] d,
                      input logic f, input logic ec);
    logic exp_v;
    logic set_o;
    logic set_u;
    exp_v = 1'b0;
    set_o = 1'b0;
    set_u = 1'b0;
    if (f) begin
      mstk.delete();
    end else if (w && !r) begin
      if (mstk.size() < 8) mstk.push_back(d);
      else set_o = 1'b1;
    end else if (!w && r) begin
      if (mstk.size() > 0) begin
        m_out = mstk.pop_back();
        sb.push_back(m_out);
        exp_v = 1'b1;
      end else begin
        set_u = 1'b1;
      end
    end else if (w && r) begin
      if (mstk.size() > 0) begin
        m_out = mstk[mstk.size()-1];
        mstk[mstk.size()-1] = d;
      end else begin
        m_out = d;
      end
      sb.push_back(m_out);
      exp_v = 1'b1;
    end
    m_ovf = set_o ? 1'b1 : (ec ? 1'b0 : m_ovf);
    m_unf = set_u ? 1'b1 : (ec ? 1'b0 : m_unf);

    wn = w; rn = r; din = d; flush = f; err_clr = ec;
    @(posedge clk);
    #1;
    wn = 1'b0; rn = 1'b0; flush = 1'b0; err_clr = 1'b0;

    chk("out_valid", out_valid, exp_v);
    if (out_valid) begin
      chk("sb_depth", sb.size() > 0, 1'b1);
      if (sb.size() > 0) chk("sb_out", dout, sb.pop_front());
    end
    chk_status();
  endtask

  task automatic push(input logic [7:0] d); step(1'b1, 1'b0, d, 1'b0, 1'b0); endtask
  task automatic pop();                     step(1'b0, 1'b1, 8'd0, 1'b0, 1'b0); endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_err = 0;
    n_chk = 0;
    model_reset();
    rst = 1'b1; wn = 1'b0; rn = 1'b0; din = 8'd0; flush = 1'b0; err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk_status();
    rst = 1'b0;

    // LIFO order
    push(8'd100); push(8'd150); push(8'd200); push(8'd40);
    push(8'd70);  push(8'd65);  push(8'd15);
    chk("af_at_7", almost_full, 1'b1);
    pop();
    chk("first_pop", dout, 8'd15);
    repeat (6) pop();
    chk("last_pop", dout, 8'd100);
    chk("drained_empty", empty, 1'b1);

    // Full and overflow
    for (int i = 1; i <= 8; i++) push(8'(i));
    chk("full_at_8", full, 1'b1);
    push(8'd99);
    chk("ovf_count", count, 4'd8);
    pop();
    chk("ovf_no_99", dout, 8'd8);
    repeat (7) pop();
    step(1'b0, 1'b0, 8'd0, 1'b0, 1'b1);

    // Underflow and err_clr
    pop();
    chk("unf_set", underflow, 1'b1);
    step(1'b0, 1'b0, 8'd0, 1'b0, 1'b1);
    chk("unf_clr", underflow, 1'b0);
    pop();
    step(1'b0, 1'b1, 8'd0, 1'b0, 1'b1);
    chk("unf_wins", underflow, 1'b1);
    step(1'b0, 1'b0, 8'd0, 1'b0, 1'b1);

    // Replace top
    push(8'd10); push(8'd20);
    step(1'b1, 1'b1, 8'd33, 1'b0, 1'b0);
    chk("repl_old_top", dout, 8'd20);
    chk("repl_count", count, 4'd2);
    pop();
    chk("repl_new_top", dout, 8'd33);
    pop();
    chk("repl_bottom", dout, 8'd10);

    // Pass-through on empty
    step(1'b1, 1'b1, 8'd77, 1'b0, 1'b0);
    chk("pass_out", dout, 8'd77);
    chk("pass_empty", empty, 1'b1);

    // Flush
    for (int i = 0; i < 5; i++) push(8'(50 + i));
    step(1'b1, 1'b1, 8'd1, 1'b1, 1'b0);
    chk("flush_out_hold", dout, 8'd77);
    pop();
    chk("flush_unf", underflow, 1'b1);
    step(1'b0, 1'b0, 8'd0, 1'b0, 1'b1);

    // Asynchronous reset between edges
    push(8'd3); push(8'd4); push(8'd5);
    pop();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("arst_count", count, 4'd0);
    chk("arst_out", dout, 8'd0);
    chk("arst_empty", empty, 1'b1);
    #2;
    rst = 1'b0;
    push(8'd9);
    pop();
    chk("post_rst_pop", dout, 8'd9);

    // Random mix of requests
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 1)) | 1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 1)),
           8'($urandom),
           1'($urandom_range(0, 24) == 0),
           1'($urandom_range(0, 9) == 0));
    end

    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
